sha_work_dispatcher: RTL and testbench

- Host-side controller for the SHA mining block.
- Assembles one 96-byte work unit from a byte stream into the 256-bit midState and 512-bit headData registers, then arms and runs the miner.
- Watches the miner's flag/goldenNonce outputs and returns a 5-byte result frame on a byte-wide valid/ready transmit stream.
- Sits between the UART/host byte interface and the top-level SHA block.

---
 rtl/sha_work_dispatcher.sv | 141 ++++++++++++++
 tb/tb_sha_work_dispatcher.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_work_dispatcher.sv
// Host-side dispatcher for the SHA miner: assembles a 96-byte work unit, runs
// the miner until flag, timeout or host abort, then returns a 5-byte result.
module sha_work_dispatcher #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [255:0] mid_state,
  output logic [511:0] head_data,
  output logic         load_state,
  output logic         solve_en,
  input  logic         flag,
  input  logic [31:0]  golden_nonce,
  output logic         busy
);

  // state | meaning
  // RECV  | shifting in work bytes, miner held cleared
  // ARM   | work unit published, miner counters released
  // SOLVE | miner running, watching flag / timeout / host abort
  // SEND  | returning status + nonce frame
  typedef enum logic [1:0] {RECV, ARM, SOLVE, SEND} state_t;

  state_t         state_q;
  logic [767:0]   shift_q;
  logic [767:0]   shift_d;
  logic [6:0]     cnt_q;
  logic [255:0]   mid_q;
  logic [511:0]   head_q;
  logic           load_q;
  logic           solve_q;
  logic [31:0]    timer_q;
  logic [31:0]    nonce_q;
  logic [7:0]     status_q;
  logic [2:0]     idx_q;
  logic           txv_q;

  assign shift_d = {shift_q[759:0], rx_data};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= RECV;
      shift_q  <= '0;
      cnt_q    <= '0;
      mid_q    <= '0;
      head_q   <= '0;
      load_q   <= 1'b0;
      solve_q  <= 1'b0;
      timer_q  <= '0;
      nonce_q  <= '0;
      status_q <= '0;
      idx_q    <= '0;
      txv_q    <= 1'b0;
    end else begin
      case (state_q)
        RECV: begin
          if (rx_valid) begin
            shift_q <= shift_d;
            if (cnt_q == 7'd95) begin
              cnt_q   <= '0;
              mid_q   <= shift_d[767:512];
              head_q  <= shift_d[511:0];
              load_q  <= 1'b1;
              state_q <= ARM;
            end else begin
              cnt_q <= cnt_q + 7'd1;
            end
          end
        end
        ARM: begin
          solve_q <= 1'b1;
          // Down-counter: terminal count 0 lands on the TIMEOUT_CYCLES-th SOLVE cycle.
          timer_q <= TIMEOUT_CYCLES - 32'd1;
          state_q <= SOLVE;
        end
        SOLVE: begin
          timer_q <= timer_q - 32'd1;
          if (rx_valid) begin
            shift_q <= shift_d;
            cnt_q   <= 7'd1;
            load_q  <= 1'b0;
            solve_q <= 1'b0;
            state_q <= RECV;
          end else if (flag) begin
            nonce_q  <= golden_nonce;
            status_q <= 8'h01;
            load_q   <= 1'b0;
            solve_q  <= 1'b0;
            txv_q    <= 1'b1;
            idx_q    <= '0;
            state_q  <= SEND;
          end else if (timer_q == 32'd0) begin
            nonce_q  <= '0;
            status_q <= 8'h00;
            load_q   <= 1'b0;
            solve_q  <= 1'b0;
            txv_q    <= 1'b1;
            idx_q    <= '0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx_q == 3'd4) begin
              txv_q   <= 1'b0;
              idx_q   <= '0;
              state_q <= RECV;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: state_q <= RECV;
      endcase
    end
  end

  always_comb begin
    tx_data = status_q;
    case (idx_q)
      3'd1:    tx_data = nonce_q[31:24];
      3'd2:    tx_data = nonce_q[23:16];
      3'd3:    tx_data = nonce_q[15:8];
      3'd4:    tx_data = nonce_q[7:0];
      default: tx_data = status_q;
    endcase
  end

  assign tx_valid   = txv_q;
  assign mid_state  = mid_q;
  assign head_data  = head_q;
  assign load_state = load_q;
  assign solve_en   = solve_q;
  assign busy       = (state_q != RECV);

endmodule

// File: tb/tb_sha_work_dispatcher.sv
// Bench for sha_work_dispatcher: transaction-level model (byte queues, frame
// queue) compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_sha_work_dispatcher;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [255:0] mid_state;
  logic [511:0] head_data;
  logic         load_state;
  logic         solve_en;
  logic         flag = 1'b0;
  logic [31:0]  golden_nonce = '0;
  logic         busy;

  int checks = 0;
  int errors = 0;

  sha_work_dispatcher #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mid_state(mid_state), .head_data(head_data), .load_state(load_state),
    .solve_en(solve_en), .flag(flag), .golden_nonce(golden_nonce), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: 0 idle/receiving, 1 armed, 2 solving, 3 sending
  int           m_phase = 0;
  int           m_solve = 0;
  logic [7:0]   m_unit[$];
  logic [7:0]   m_fq[$];
  logic [255:0] m_mid = '0;
  logic [511:0] m_head = '0;
  logic [7:0]   tx_log[$];

  initial begin
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) begin
        m_phase = 0; m_solve = 0; m_unit.delete(); m_fq.delete();
        m_mid = '0; m_head = '0;
      end else begin
        case (m_phase)
          0: if (rx_valid) begin
            m_unit.push_back(rx_data);
            if (m_unit.size() == 96) begin
              for (int i = 0; i < 32; i++) m_mid[255-8*i -: 8] = m_unit[i];
              for (int i = 0; i < 64; i++) m_head[511-8*i -: 8] = m_unit[32+i];
              m_unit.delete();
              m_phase = 1;
            end
          end
          1: begin m_phase = 2; m_solve = 0; end
          2: begin
            m_solve++;
            if (rx_valid) begin
              m_unit.delete(); m_unit.push_back(rx_data); m_phase = 0;
            end else if (flag) begin
              m_fq.delete();
              m_fq.push_back(8'h01);
              for (int i = 3; i >= 0; i--) m_fq.push_back(golden_nonce[8*i +: 8]);
              m_phase = 3;
            end else if (m_solve == TO) begin
              m_fq.delete();
              for (int i = 0; i < 5; i++) m_fq.push_back(8'h00);
              m_phase = 3;
            end
          end
          default: if (tx_ready) begin
            void'(m_fq.pop_front());
            if (m_fq.size() == 0) m_phase = 0;
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (n_rst) begin
        chk("busy", busy, m_phase != 0);
        chk("load_state", load_state, (m_phase == 1) || (m_phase == 2));
        chk("solve_en", solve_en, m_phase == 2);
        chk("tx_valid", tx_valid, m_phase == 3);
        chk("mid_state", mid_state, m_mid);
        chk("head_data", head_data, m_head);
        if (m_phase == 3 && m_fq.size() > 0) chk("tx_data", tx_data, m_fq[0]);
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      end
    end
  end

  logic [7:0] ub[96];

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 96; i++) ub[i] = 8'($urandom);
  endtask

  task automatic send_unit(input bit gaps);
    for (int i = 0; i < 96; i++) begin
      if (gaps && $urandom_range(3) == 0) idle($urandom_range(1, 3));
      put_byte(ub[i]);
    end
  endtask

  task automatic pulse_flag(input logic [31:0] n);
    flag = 1'b1; golden_nonce = n;
    @(posedge clk); #1;
    flag = 1'b0; golden_nonce = $urandom;
  endtask

  task automatic drain(input int mode);
    int k;
    for (k = 0; k < 300 && busy; k++) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (k % 3 == 0);
        default: begin
          tx_ready = 1'($urandom_range(1));
          rx_valid = 1'($urandom_range(1));
          rx_data  = 8'($urandom);
        end
      endcase
      @(posedge clk); #1;
    end
    tx_ready = 1'b0; rx_valid = 1'b0;
    if (busy) chk("drain_timeout", busy, 1'b0);
  endtask

  task automatic chk_frame(input string name, input logic [39:0] exp);
    chk({name, "_len"}, tx_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < tx_log.size()) chk(name, tx_log[i], exp[39-8*i -: 8]);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_tx_data"}, tx_data, 0);
    chk({name, "_tx_valid"}, tx_valid, 0);
    chk({name, "_mid"}, mid_state, 0);
    chk({name, "_head"}, head_data, 0);
    chk({name, "_load"}, load_state, 0);
    chk({name, "_solve"}, solve_en, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  initial begin
    int cnt;
    #23;
    chk_all_zero("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Ordered unit 00..5F, no gaps
    for (int i = 0; i < 96; i++) ub[i] = 8'(i);
    send_unit(1'b0);
    chk("t1_load_rise", load_state, 1);
    chk("t1_solve_not_yet", solve_en, 0);
    chk("t1_mid_hi", mid_state[255:248], 8'h00);
    chk("t1_mid_lo", mid_state[7:0], 8'h1F);
    chk("t1_head_hi", head_data[511:504], 8'h20);
    chk("t1_head_lo", head_data[7:0], 8'h5F);
    @(posedge clk); #1;
    chk("t1_solve_rise", solve_en, 1);
    idle(9);
    tx_log.delete();
    pulse_flag(32'hDEADBEEF);
    chk("t1_txv", tx_valid, 1);
    chk("t1_load_fall", load_state, 0);
    chk("t1_solve_fall", solve_en, 0);
    drain(0);
    chk_frame("t1_frame", 40'h01_DE_AD_BE_EF);
    chk("t1_busy_end", busy, 0);

    // Timeout
    fill_rand(); send_unit(1'b1);
    tx_log.delete();
    cnt = 0;
    for (int k = 0; k < 100 && !tx_valid; k++) begin
      @(posedge clk); #1;
      if (solve_en) cnt++;
    end
    chk("to_cycles", cnt, 16);
    drain(0);
    chk_frame("to_frame", 40'h0);

    // Back-pressured frame
    fill_rand(); send_unit(1'b0);
    idle(3);
    tx_log.delete();
    pulse_flag(32'h12345678);
    drain(1);
    chk_frame("bp_frame", 40'h01_12_34_56_78);

    // Host abort on SOLVE cycle 5
    fill_rand(); send_unit(1'b0);
    idle(5);
    tx_log.delete();
    put_byte(8'hAA);
    chk("ab_busy", busy, 0);
    chk("ab_txv", tx_valid, 0);
    fill_rand(); ub[0] = 8'hAA;
    for (int i = 1; i < 96; i++) put_byte(ub[i]);
    chk("ab_load", load_state, 1);
    chk("ab_mid_hi", mid_state[255:248], 8'hAA);
    chk("ab_no_frame", tx_log.size(), 0);
    pulse_flag(32'h0BADF00D);
    drain(0);

    // Reset during SEND after two bytes
    fill_rand(); send_unit(1'b1);
    idle(2);
    pulse_flag(32'h55AA1234);
    tx_ready = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    n_rst = 1'b0; #1;
    chk_all_zero("rst_send");
    tx_ready = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    fill_rand(); send_unit(1'b0);
    idle(4);
    tx_log.delete();
    pulse_flag(32'h87654321);
    drain(2);
    chk_frame("post_rst_frame", 40'h01_87_65_43_21);

    // Flag on the same cycle as timeout expiry
    fill_rand(); send_unit(1'b0);
    idle(16);
    tx_log.delete();
    pulse_flag(32'hCAFEF00D);
    drain(0);
    chk_frame("tie_frame", 40'h01_CA_FE_F0_0D);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      fill_rand(); send_unit(1'b1);
      idle($urandom_range(0, 20));
      pulse_flag($urandom);
      drain(2);
      idle($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
